packed_port_serializer: RTL



---
 rtl/packed_port_serializer_if.sv | 22 ++
 rtl/packed_port_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/packed_port_serializer_if.sv
// ---------------------------------------------------------------------------
// packed_port_serializer_if
//
// Carries the parallel word that packed_port_serializer reads. The producer
// side (master) owns x; the serializer (slave) only ever reads it.
//
// Parameters:
//   WIDTH  bit width of the packed field x
//
// Signals:
//   x [WIDTH-1:0]  parallel word, written by master, read by slave
// ---------------------------------------------------------------------------
interface packed_port_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] x;

  modport master (output x);
  modport slave  (input  x);

endinterface : packed_port_serializer_if

// File: rtl/packed_port_serializer.sv
// ---------------------------------------------------------------------------
// packed_port_serializer
//
// Captures the packed word p.x on a start request and streams it out one bit
// per accepted valid/ready handshake. After the final bit is accepted the
// block returns to idle and pulses o_done for one cycle.
//
// Parameters:
//   WIDTH      data bits per frame (>= 2)
//   MSB_FIRST  0: bit 0 leaves first; 1: bit WIDTH-1 leaves first
//
// Optional feature (compile-time macro PACKED_PORT_SERIALIZER_PARITY_EN):
//   when defined, one extra even-parity bit (XOR of the captured word)
//   follows the data bits and carries o_last. Frame length is WIDTH+1.
//   When undefined, the frame is exactly WIDTH bits.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   p        interface slave modport, p.x is the word to capture
//   i_start  capture p.x and begin a frame (honoured in IDLE only)
//   i_ready  downstream accepts o_bit this cycle
//   o_valid  o_bit is valid (frame in progress)
//   o_bit    current serial bit
//   o_last   current bit is the final bit of the frame
//   o_busy   frame in progress
//   o_done   one-cycle pulse after the final bit is accepted
//
// Every output is decoded from registered state only; neither i_ready nor
// p.x reaches an output combinationally.
// ---------------------------------------------------------------------------
module packed_port_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  packed_port_serializer_if.slave  p,
  input  logic                     i_start,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic                     o_bit,
  output logic                     o_last,
  output logic                     o_busy,
  output logic                     o_done
);

`ifdef PACKED_PORT_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  // The shift register holds the whole frame, parity bit included, so the
  // parity bit simply falls out of the same shift path as the data bits.
  localparam int SR_W  = FRAME_LEN;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [SR_W-1:0]   load_word;
  logic [SR_W-1:0]   sr_shifted;
  logic              out_bit;

  // -------------------------------------------------------------------------
  // Frame image loaded at capture. The output end of the register holds the
  // first bit to send; the parity bit (if any) sits at the far end so it is
  // the last one to arrive at the output.
  // -------------------------------------------------------------------------
`ifdef PACKED_PORT_SERIALIZER_PARITY_EN
  logic parity;
  assign parity = ^p.x;

  if (MSB_FIRST) begin : g_load_msb
    assign load_word = {p.x, parity};
  end else begin : g_load_lsb
    assign load_word = {parity, p.x};
  end
`else
  assign load_word = p.x;
`endif

  // -------------------------------------------------------------------------
  // One-position shift toward the output end with zero fill.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < SR_W; gi++) begin : g_shift
    if (MSB_FIRST) begin : g_msb
      if (gi == 0) begin : g_fill
        assign sr_shifted[gi] = 1'b0;
      end else begin : g_move
        assign sr_shifted[gi] = sr_q[gi-1];
      end
    end else begin : g_lsb
      if (gi == SR_W - 1) begin : g_fill
        assign sr_shifted[gi] = 1'b0;
      end else begin : g_move
        assign sr_shifted[gi] = sr_q[gi+1];
      end
    end
  end

  if (MSB_FIRST) begin : g_out_msb
    assign out_bit = sr_q[SR_W-1];
  end else begin : g_out_lsb
    assign out_bit = sr_q[0];
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          sr_d    = load_word;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // i_start is deliberately not looked at here: a request arriving
        // mid-frame, even on the final transfer, is dropped.
        if (i_ready) begin
          sr_d = sr_shifted;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (decoded from registers only)
  // -------------------------------------------------------------------------
  assign o_valid = (state_q == SHIFT);
  assign o_busy  = (state_q == SHIFT);
  assign o_bit   = (state_q == SHIFT) & out_bit;
  assign o_last  = (state_q == SHIFT) & (cnt_q == LAST_CNT);
  assign o_done  = done_q;

endmodule : packed_port_serializer
